// File: rtl/crc16_frame_checker.sv
// ---------------------------------------------------------------------------
// crc16_frame_checker
//
// Receive-side frame checker. Each frame is a byte stream ending in a 2-byte
// CRC-16/X.25 FCS (low byte first). The CRC runs over every byte, FCS
// included, and a good frame leaves the residue 16'hF0B8. Frame length is
// checked against MIN_LEN/MAX_LEN. One status record is issued per frame,
// and running good/bad frame counters are kept.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     byte stream handshake (s_ready low only in DONE)
//   s_data              input byte
//   s_last              marks the last byte (high FCS byte)
//   s_abort             discard the frame in progress
//   res_valid           one-cycle status pulse
//   res_ok              CRC good and length legal
//   res_err_crc         residue is not 16'hF0B8
//   res_err_len         length outside [MIN_LEN, MAX_LEN]
//   res_len             accepted byte count, saturating at MAX_LEN+1
//   res_residue         final CRC register value
//   good_cnt/bad_cnt    saturating frame counters
// ---------------------------------------------------------------------------
module crc16_frame_checker #(
  parameter int MIN_LEN = 3,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             s_abort,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_err_crc,
  output logic             res_err_len,
  output logic [LEN_W-1:0] res_len,
  output logic [15:0]      res_residue,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
);

  localparam logic [15:0]      CRC_INIT = 16'hFFFF;
  localparam logic [15:0]      CRC_GOOD = 16'hF0B8;
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             res_valid_q;
  logic             res_ok_q;
  logic             res_err_crc_q;
  logic             res_err_len_q;
  logic [LEN_W-1:0] res_len_q;
  logic [15:0]      res_residue_q;
  logic [15:0]      good_cnt_q;
  logic [15:0]      bad_cnt_q;

  logic             accept;
  logic             enter_done;
  logic             err_crc_d;
  logic             err_len_d;

  // Reflected CRC-16 (poly 0x1021 reversed = 0x8408), one byte LSB first.
  function automatic logic [15:0] crc_update(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  assign s_ready = (state_q != DONE);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        // An abort in IDLE swallows the byte instead of starting a frame.
        if (accept && !s_abort) begin
          crc_d   = crc_update(CRC_INIT, s_data);
          len_d   = LEN_W'(1);
          state_d = s_last ? DONE : RECV;
        end
      end
      RECV: begin
        if (s_abort) begin
          crc_d   = CRC_INIT;
          len_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          crc_d = crc_update(crc_q, s_data);
          // Overlength frames keep being CRC'd; only the count saturates.
          len_d = (len_q < LEN_SAT) ? len_q + LEN_W'(1) : len_q;
          if (s_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        crc_d   = CRC_INIT;
        len_d   = '0;
        state_d = IDLE;
      end
      default: begin
        crc_d   = CRC_INIT;
        len_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Status is computed from the post-update values so it is registered on
  // the same edge that accepts the s_last byte and shows with res_valid.
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign err_crc_d  = (crc_d != CRC_GOOD);
  assign err_len_d  = (len_d < LEN_MIN) || (len_d > LEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      crc_q         <= CRC_INIT;
      len_q         <= '0;
      res_valid_q   <= 1'b0;
      res_ok_q      <= 1'b0;
      res_err_crc_q <= 1'b0;
      res_err_len_q <= 1'b0;
      res_len_q     <= '0;
      res_residue_q <= 16'h0000;
      good_cnt_q    <= 16'h0000;
      bad_cnt_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      res_valid_q <= enter_done;
      if (enter_done) begin
        res_ok_q      <= !err_crc_d && !err_len_d;
        res_err_crc_q <= err_crc_d;
        res_err_len_q <= err_len_d;
        res_len_q     <= len_d;
        res_residue_q <= crc_d;
        if (!err_crc_d && !err_len_d) begin
          if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
        end else begin
          if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
        end
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_ok      = res_ok_q;
  assign res_err_crc = res_err_crc_q;
  assign res_err_len = res_err_len_q;
  assign res_len     = res_len_q;
  assign res_residue = res_residue_q;
  assign good_cnt    = good_cnt_q;
  assign bad_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_crc16_frame_checker
//
// Directed testbench for crc16_frame_checker. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_crc16_frame_checker;

  localparam int MIN_LEN = 3;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_abort;
  logic             res_valid;
  logic             res_ok;
  logic             res_err_crc;
  logic             res_err_len;
  logic [LEN_W-1:0] res_len;
  logic [15:0]      res_residue;
  logic [15:0]      good_cnt;
  logic [15:0]      bad_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;   // res_valid cycles seen
  int nready_cnt = 0;  // cycles with s_ready low
  int exp_good = 0;
  int exp_bad = 0;

  byte_q_t good_frame;
  byte_q_t bad_frame;
  byte_q_t short_frame;

  crc16_frame_checker #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_abort    (s_abort),
    .res_valid  (res_valid),
    .res_ok     (res_ok),
    .res_err_crc(res_err_crc),
    .res_err_len(res_err_len),
    .res_len    (res_len),
    .res_residue(res_residue),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_valid) pulse_cnt++;
    if (!s_ready) nready_cnt++;
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_byte(input logic [7:0] d, input logic last, input logic abort);
    bit r;
    int tries;
    tries = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_abort = abort;
    do begin
      r = s_ready;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end while (!r && tries < 8);
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake: s_ready got 0 required 1 within 8 cycles");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t q, input int max_gap);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          s_data = 8'($urandom);
          s_last = 1'($urandom);
          @(negedge clk);
        end
        s_last = 1'b0;
      end
      drive_byte(q[i], (i == q.size() - 1), 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", s_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", res_valid); end
    n_cmp++; if ({res_ok, res_err_crc, res_err_len} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b required 000", {res_ok, res_err_crc, res_err_len}); end
    n_cmp++; if (res_len !== 9'd0 || res_residue !== 16'h0000) begin n_bad++; $display("FAIL reset_len_res: got %0d/%h required 0/0000", res_len, res_residue); end
    n_cmp++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", good_cnt, bad_cnt); end
    $display("reset: released, outputs idle");
  endtask

  task automatic test_good();
    int p0;
    p0 = pulse_cnt;
    send_frame(good_frame, 0);
    exp_good++;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b required 1", res_valid); end
    n_cmp++; if (res_ok !== 1'b1 || res_err_crc !== 1'b0 || res_err_len !== 1'b0) begin n_bad++; $display("FAIL good_flags: got ok=%b crc=%b len=%b required 1 0 0", res_ok, res_err_crc, res_err_len); end
    n_cmp++; if (res_len !== 9'd11) begin n_bad++; $display("FAIL good_len: got %0d required 11", res_len); end
    n_cmp++; if (res_residue !== 16'hF0B8) begin n_bad++; $display("FAIL good_residue: got %h required f0b8", res_residue); end
    n_cmp++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_bad++; $display("FAIL good_cnt: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL good_pulse_width: got %b required 0", res_valid); end
    n_cmp++; if (res_len !== 9'd11 || res_ok !== 1'b1) begin n_bad++; $display("FAIL good_hold: got len=%0d ok=%b required 11 1", res_len, res_ok); end
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL good_pulses: got %0d required 1", pulse_cnt - p0); end
    $display("good frame: len=%0d residue=%h ok=%b good_cnt=%0d", res_len, res_residue, res_ok, good_cnt);
  endtask

  task automatic test_bad_crc();
    send_frame(bad_frame, 0);
    exp_bad++;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL badcrc_valid: got %b required 1", res_valid); end
    n_cmp++; if (res_err_crc !== 1'b1 || res_ok !== 1'b0 || res_err_len !== 1'b0) begin n_bad++; $display("FAIL badcrc_flags: got crc=%b ok=%b len=%b required 1 0 0", res_err_crc, res_ok, res_err_len); end
    n_cmp++; if (res_len !== 9'd11) begin n_bad++; $display("FAIL badcrc_len: got %0d required 11", res_len); end
    n_cmp++; if (bad_cnt !== 16'(exp_bad) || good_cnt !== 16'(exp_good)) begin n_bad++; $display("FAIL badcrc_cnt: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    $display("bad-crc frame: len=%0d residue=%h err_crc=%b bad_cnt=%0d", res_len, res_residue, res_err_crc, bad_cnt);
  endtask

  task automatic test_back_to_back();
    int p0, r0;
    @(negedge clk);
    p0 = pulse_cnt;
    r0 = nready_cnt;
    // Short frame: CRC of FF,FF from FFFF lands exactly on 0000.
    send_frame(short_frame, 0);
    exp_bad++;
    n_cmp++; if (res_valid !== 1'b1 || res_err_len !== 1'b1) begin n_bad++; $display("FAIL short_flags: got valid=%b err_len=%b required 1 1", res_valid, res_err_len); end
    n_cmp++; if (res_len !== 9'd2 || res_residue !== 16'h0000 || res_ok !== 1'b0) begin n_bad++; $display("FAIL short_len_res: got %0d/%h ok=%b required 2/0000 0", res_len, res_residue, res_ok); end
    n_cmp++; if (bad_cnt !== 16'(exp_bad)) begin n_bad++; $display("FAIL short_cnt: got %0d required %0d", bad_cnt, exp_bad); end
    $display("short frame: len=%0d residue=%h err_len=%b bad_cnt=%0d", res_len, res_residue, res_err_len, bad_cnt);
    // Next frame starts while the checker is in DONE.
    send_frame(good_frame, 2);
    exp_good++;
    n_cmp++; if (res_valid !== 1'b1 || res_ok !== 1'b1 || res_len !== 9'd11) begin n_bad++; $display("FAIL b2b_result: got valid=%b ok=%b len=%0d required 1 1 11", res_valid, res_ok, res_len); end
    n_cmp++; if (good_cnt !== 16'(exp_good)) begin n_bad++; $display("FAIL b2b_cnt: got %0d required %0d", good_cnt, exp_good); end
    @(negedge clk);
    n_cmp++; if (nready_cnt - r0 !== 2) begin n_bad++; $display("FAIL b2b_ready_low: got %0d cycles required 2", nready_cnt - r0); end
    n_cmp++; if (pulse_cnt - p0 !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d required 2", pulse_cnt - p0); end
    $display("back-to-back: ok=%b len=%0d good_cnt=%0d", res_ok, res_len, good_cnt);
  endtask

  task automatic test_overlength();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < MAX_LEN + 3; i++) drive_byte(8'(i), 1'b0, 1'b0);
    n_cmp++; if (res_valid !== 1'b0 || pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL over_early: got valid=%b pulses=%0d required 0 0", res_valid, pulse_cnt - p0); end
    drive_byte(8'hA5, 1'b1, 1'b0);
    exp_bad++;
    n_cmp++; if (res_valid !== 1'b1 || res_err_len !== 1'b1 || res_ok !== 1'b0) begin n_bad++; $display("FAIL over_flags: got valid=%b err_len=%b ok=%b required 1 1 0", res_valid, res_err_len, res_ok); end
    n_cmp++; if (res_len !== 9'd257) begin n_bad++; $display("FAIL over_len: got %0d required 257", res_len); end
    n_cmp++; if (bad_cnt !== 16'(exp_bad)) begin n_bad++; $display("FAIL over_cnt: got %0d required %0d", bad_cnt, exp_bad); end
    $display("overlength frame: len=%0d err_len=%b bad_cnt=%0d", res_len, res_err_len, bad_cnt);
  endtask

  task automatic test_abort();
    int p0;
    @(negedge clk);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) drive_byte(good_frame[i], 1'b0, 1'b0);
    drive_byte(8'hAA, 1'b0, 1'b1);  // abort in RECV, byte dropped
    drive_byte(8'h55, 1'b0, 1'b1);  // abort in IDLE, byte dropped
    send_frame(good_frame, 1);
    exp_good++;
    n_cmp++; if (res_valid !== 1'b1 || res_ok !== 1'b1 || res_len !== 9'd11) begin n_bad++; $display("FAIL abort_result: got valid=%b ok=%b len=%0d required 1 1 11", res_valid, res_ok, res_len); end
    n_cmp++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_bad++; $display("FAIL abort_cnt: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    @(negedge clk);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL abort_pulses: got %0d required 1", pulse_cnt - p0); end
    $display("abort then good frame: ok=%b len=%0d good_cnt=%0d", res_ok, res_len, good_cnt);
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int i = 0; i < 4; i++) drive_byte(good_frame[i], 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if ({res_valid, res_ok, res_err_crc, res_err_len} !== 4'b0000 || res_len !== 9'd0 || res_residue !== 16'h0000) begin n_bad++; $display("FAIL rstmid_res: got v=%b ok=%b len=%0d res=%h required all 0", res_valid, res_ok, res_len, res_residue); end
    n_cmp++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d/%0d required 0/0", good_cnt, bad_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_good = 0;
    exp_bad = 0;
    @(negedge clk);
    p0 = pulse_cnt;
    send_frame(good_frame, 1);
    exp_good++;
    n_cmp++; if (res_valid !== 1'b1 || res_ok !== 1'b1 || res_len !== 9'd11 || good_cnt !== 16'(exp_good)) begin n_bad++; $display("FAIL rstmid_next: got valid=%b ok=%b len=%0d good=%0d required 1 1 11 1", res_valid, res_ok, res_len, good_cnt); end
    @(negedge clk);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL rstmid_pulses: got %0d required 1", pulse_cnt - p0); end
    $display("reset mid-frame then good frame: ok=%b good_cnt=%0d", res_ok, good_cnt);
  endtask

  task automatic test_saturation();
    force dut.bad_cnt_q = 16'hFFFE;
    #1;
    release dut.bad_cnt_q;
    @(negedge clk);
    send_frame(short_frame, 0);
    n_cmp++; if (bad_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h required ffff", bad_cnt); end
    send_frame(short_frame, 0);
    n_cmp++; if (res_valid !== 1'b1 || bad_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got valid=%b cnt=%h required 1 ffff", res_valid, bad_cnt); end
    n_cmp++; if (good_cnt !== 16'(exp_good)) begin n_bad++; $display("FAIL sat_good: got %0d required %0d", good_cnt, exp_good); end
    $display("saturation: bad_cnt=%h good_cnt=%0d", bad_cnt, good_cnt);
  endtask

  initial begin
    good_frame  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    bad_frame   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    short_frame = '{8'hFF, 8'hFF};
    test_reset();
    test_good();
    test_bad_crc();
    test_back_to_back();
    test_overlength();
    test_abort();
    test_reset_mid();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
